// File: rtl/fp_class_gen.sv
// fp_class_gen: emits bursts of IEEE-754 bit patterns of one requested class, payload from a Galois LFSR
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready while idle)
//   req_class[3:0], req_count[7:0]  class code (classifier ordering) and burst length minus one
//   out_valid/out_ready             output handshake
//   out_data[WIDTH-1:0]             generated pattern; out_class its class; out_last end of burst
//   err                             one-cycle pulse after an invalid class code was accepted
module fp_class_gen #(
  parameter int          WIDTH = 16,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_class,
  input  logic [7:0]       req_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_class,
  output logic             out_last,
  output logic             err
);
  localparam int EXP_W = (WIDTH == 64) ? 11 : (WIDTH == 32) ? 8 : 5;
  localparam int MAN_W = WIDTH - 1 - EXP_W;
  localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY = 32'h8020_0003;
  typedef enum logic {IDLE, GEN} state_t;
  state_t state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [WIDTH-1:0] data_q, data_d, gen_val;
  logic [3:0] class_q, class_d, cls;
  logic [7:0] rem_q, rem_d;
  logic last_q, last_d, err_q, err_d;
  logic [MAN_W-1:0] m, den_m;
  logic [MAN_W-2:0] nan_lo, snan_lo;
  logic [EXP_W-1:0] e, e_cl;
  logic neg, acc, hs;
  assign lfsr_nx = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'h0);
  assign cls     = (state_q == IDLE) ? req_class : class_q;
  assign neg     = (cls >= 4'd2) && (cls <= 4'd5);
  assign m       = MAN_W'({lfsr_q, lfsr_q});
  assign e       = lfsr_q[16 +: EXP_W];
  // normal exponent must avoid the zero/denormal and inf/NaN encodings
  assign e_cl    = (e == '0) ? EXP_W'(1) : (&e) ? ~EXP_W'(1) : e;
  assign nan_lo  = m[MAN_W-2:0];
  assign snan_lo = (nan_lo == '0) ? (MAN_W-1)'(1) : nan_lo;
  assign den_m   = (m == '0) ? MAN_W'(1) : m;
  always_comb begin
    gen_val = '0;
    case (cls)
      4'd0:       gen_val = {lfsr_q[31], {EXP_W{1'b1}}, 1'b0, snan_lo};
      4'd1:       gen_val = {lfsr_q[31], {EXP_W{1'b1}}, 1'b1, nan_lo};
      4'd2, 4'd9: gen_val = {neg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      4'd3, 4'd8: gen_val = {neg, e_cl, m};
      4'd4, 4'd7: gen_val = {neg, {EXP_W{1'b0}}, den_m};
      default:    gen_val = {neg, {(WIDTH-1){1'b0}}};
    endcase
  end
  assign acc = (state_q == IDLE) && req_valid;
  assign hs  = (state_q == GEN) && out_ready;
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    class_d = class_q;
    rem_d   = rem_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (acc && req_class > 4'd9) begin
      err_d = 1'b1;
    end else if (acc) begin
      state_d = GEN;
      class_d = req_class;
      rem_d   = req_count;
      data_d  = gen_val;
      last_d  = (req_count == 8'd0);
      lfsr_d  = lfsr_nx;
    end else if (hs && last_q) begin
      state_d = IDLE;
      last_d  = 1'b0;
    end else if (hs) begin
      data_d = gen_val;
      rem_d  = rem_q - 8'd1;
      last_d = (rem_q == 8'd1);
      lfsr_d = lfsr_nx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_NZ;
      data_q  <= '0;
      class_q <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      class_q <= class_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end
  assign req_ready = (state_q == IDLE);
  assign out_valid = (state_q == GEN);
  assign out_data  = data_q;
  assign out_class = class_q;
  assign out_last  = last_q;
  assign err       = err_q;
endmodule

// File: tb/tb_fp_class_gen.sv
// tb_fp_class_gen: directed self-checking bench for fp_class_gen at WIDTH=16, SEED=1
module tb_fp_class_gen;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, out_valid, out_ready = 1'b1, out_last, err;
  logic [3:0] req_class = '0, out_class;
  logic [7:0] req_count = '0;
  logic [15:0] out_data;
  int errors = 0, checks = 0;
  fp_class_gen #(.WIDTH(16), .SEED(32'h1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_count(req_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_class(out_class),
    .out_last(out_last), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] step(input logic [31:0] r);
    return (r >> 1) ^ (r[0] ? 32'h8020_0003 : 32'h0);
  endfunction
  function automatic logic [15:0] model(input logic [3:0] c, input logic [31:0] r);
    logic s;
    logic [9:0] m;
    logic [4:0] e;
    m = r[9:0];
    e = r[20:16];
    s = (c >= 4'd2 && c <= 4'd5);
    if (e == 5'd0) e = 5'd1;
    else if (e == 5'd31) e = 5'd30;
    case (c)
      4'd0:       model = {r[31], 5'h1f, 1'b0, (m[8:0] == 9'd0) ? 9'd1 : m[8:0]};
      4'd1:       model = {r[31], 5'h1f, 1'b1, m[8:0]};
      4'd2, 4'd9: model = {s, 5'h1f, 10'h0};
      4'd3, 4'd8: model = {s, e, m};
      4'd4, 4'd7: model = {s, 5'h0, (m == 10'd0) ? 10'd1 : m};
      default:    model = {s, 15'h0};
    endcase
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic request(input logic [3:0] c, input logic [7:0] n);
    req_class = c;
    req_count = n;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({req_ready, out_valid, out_data, out_class, out_last, err} !== {1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b data=%h cls=%h last=%b err=%b, want 1 0 0000 0 0 0", req_ready, out_valid, out_data, out_class, out_last, err);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_nan;
    do_reset();
    request(4'd1, 8'd0);
    checks++;
    if ({out_valid, out_data, out_last, out_class} !== {1'b1, 16'h7E01, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL qnan_first: vld=%b data=%h last=%b cls=%0d, want 1 7e01 1 1", out_valid, out_data, out_last, out_class);
    end
    tick();
    checks++;
    if ({out_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL qnan_turnaround: vld=%b rdy=%b, want 0 1", out_valid, req_ready);
    end
    request(4'd0, 8'd0);
    checks++;
    if (out_data[14:10] !== 5'h1f || out_data[9] !== 1'b0 || out_data[8:0] == 9'd0 || out_class !== 4'd0) begin
      errors++;
      $display("FAIL snan_fields: data=%h cls=%0d, want exp 1f, mant msb 0, mant nonzero, cls 0", out_data, out_class);
    end
    checks++;
    if (out_data !== model(4'd0, step(32'h1))) begin
      errors++;
      $display("FAIL snan_value: got %h want %h", out_data, model(4'd0, step(32'h1)));
    end
    tick();
  endtask
  task automatic test_fixed;
    logic [3:0] cl[4] = '{4'd8, 4'd7, 4'd2, 4'd5};
    logic [15:0] ex[4] = '{16'h0401, 16'h0001, 16'hFC00, 16'h8000};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      request(cl[i], 8'd0);
      checks++;
      if ({out_valid, out_data, out_class} !== {1'b1, ex[i], cl[i]}) begin
        errors++;
        $display("FAIL fixed_class%0d: vld=%b data=%h cls=%0d, want 1 %h %0d", cl[i], out_valid, out_data, out_class, ex[i], cl[i]);
      end
      tick();
    end
  endtask
  task automatic test_long_burst;
    logic [31:0] r = 32'h1;
    do_reset();
    out_ready = 1'b1;
    request(4'd3, 8'd255);
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (!out_valid || out_data[15] !== 1'b1 || out_data[14:10] == 5'h0 || out_data[14:10] == 5'h1f
          || out_last !== (i == 255) || out_data !== model(4'd3, r)) begin
        errors++;
        $display("FAIL burst256[%0d]: vld=%b data=%h last=%b, want 1 %h last=%b (neg_normal)", i, out_valid, out_data, out_last, model(4'd3, r), i == 255);
      end
      r = step(r);
      tick();
    end
    checks++;
    if ({out_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL burst256_end: vld=%b rdy=%b, want 0 1", out_valid, req_ready);
    end
  endtask
  task automatic test_backpressure;
    logic pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] r = 32'h1;
    logic [15:0] held = '0;
    logic stalled = 1'b0, done = 1'b0;
    int n_hs = 0;
    do_reset();
    request(4'd4, 8'd3);
    for (int k = 0; k < 40 && !done; k++) begin
      out_ready = pat[k % 8];
      checks++;
      if (!out_valid || out_data !== model(4'd4, r) || (stalled && out_data !== held) || out_last !== (n_hs == 3)) begin
        errors++;
        $display("FAIL stall[%0d]: vld=%b data=%h last=%b, want 1 %h last=%b", k, out_valid, out_data, out_last, model(4'd4, r), n_hs == 3);
      end
      stalled = !out_ready;
      held = out_data;
      if (out_ready) begin
        n_hs++;
        r = step(r);
        done = (n_hs == 4);
      end
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (n_hs != 4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_count: handshakes=%0d vld=%b, want 4 0", n_hs, out_valid);
    end
  endtask
  task automatic test_bad_class;
    do_reset();
    request(4'd12, 8'd0);
    checks++;
    if ({err, out_valid, req_ready} !== 3'b101) begin
      errors++;
      $display("FAIL bad_class: err=%b vld=%b rdy=%b, want 1 0 1", err, out_valid, req_ready);
    end
    tick();
    checks++;
    if ({err, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bad_class_pulse: err=%b vld=%b, want 0 0", err, out_valid);
    end
    request(4'd1, 8'd0);
    checks++;
    if (out_data !== 16'h7E01) begin
      errors++;
      $display("FAIL bad_class_lfsr: got %h want 7e01", out_data);
    end
    tick();
  endtask
  task automatic test_reset_mid;
    do_reset();
    request(4'd9, 8'd10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, out_data, out_last} !== {1'b1, 16'h7C00, 1'b0}) begin
        errors++;
        $display("FAIL pinf[%0d]: vld=%b data=%h last=%b, want 1 7c00 0", i, out_valid, out_data, out_last);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL mid_reset: vld=%b rdy=%b, want 0 1", out_valid, req_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    request(4'd1, 8'd0);
    checks++;
    if (out_data !== 16'h7E01) begin
      errors++;
      $display("FAIL mid_reset_reseed: got %h want 7e01", out_data);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_nan();
    test_fixed();
    test_long_burst();
    test_backpressure();
    test_bad_class();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
